face_box_tracker: RTL
=====================

// Module: face_box_tracker
// PURPOSE
//  Downstream of the video image processor. Once per frame, latches the raw face bounding box (x_min/x_max/y_min/y_max).
//  Rejects implausible boxes, then smooths the box with a shift-based IIR filter.
//  Tracks consecutive misses and publishes a stable box, its centre, a valid flag and a one-cycle update strobe.
//  The box overlay / OSD logic consumes these outputs.
// PARAMETERS
//  IMG_HDISP    640  active pixels per line; x_max must be < IMG_HDISP
//  IMG_VDISP    480  active lines per frame; y_max must be < IMG_VDISP
//  MIN_W        16   minimum accepted box width (x_max - x_min)
//  MIN_H        16   minimum accepted box height (y_max - y_min)
//  ALPHA_SHIFT  2    IIR gain = 1/2^ALPHA_SHIFT; 0 = no smoothing (direct load)
//  MISS_LIMIT   4    consecutive rejected frames before box_valid drops (1..15)
// PORTS
//  clk              in   1   pixel clock
//  rst_n            in   1   asynchronous active-low reset
//  per_frame_vsync  in   1   frame sync from processor, high during frame
//  x_min            in   12  raw box left, stable >=8 clk after vsync falls
//  x_max            in   12  raw box right
//  y_min            in   12  raw box top
//  y_max            in   12  raw box bottom
//  box_x_min        out  12  filtered left
//  box_x_max        out  12  filtered right
//  box_y_min        out  12  filtered top
//  box_y_max        out  12  filtered bottom
//  box_cx           out  12  (box_x_min+box_x_max)>>1, 13-bit sum, no overflow
//  box_cy           out  12  (box_y_min+box_y_max)>>1
//  box_valid        out  1   a tracked face exists
//  box_update       out  1   1-cycle strobe: outputs refreshed this frame
//  miss_cnt         out  4   consecutive rejected frames, saturates at 15
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> S_IDLE; vsync history reg 0.
//  EOF event = per_frame_vsync registered 1 and current 0 (falling edge).
//  FSM: S_IDLE -(EOF)-> S_LATCH -> S_CHECK -> S_FILT -> S_OUT -> S_IDLE; one cycle per non-idle state.
//   S_LATCH: copy the 4 inputs to raw regs.
//   S_CHECK: ok = raw_xmax>raw_xmin & raw_ymax>raw_ymin & raw_xmax<IMG_HDISP & raw_ymax<IMG_VDISP.
//            In addition, (raw_xmax-raw_xmin)>=MIN_W and (raw_ymax-raw_ymin)>=MIN_H.
//   S_FILT ok & !box_valid: load raw directly, box_valid<=1, miss_cnt<=0.
//   S_FILT ok &  box_valid: per coord d = raw-old (13-bit signed); s = d>>>ALPHA_SHIFT.
//            If s==0 and d!=0, then s = +1/-1 by sign(d). new = old+s. miss_cnt<=0.
//   S_FILT !ok: box coords held; miss_cnt<=sat(miss_cnt+1).
//            If the incremented value >= MISS_LIMIT, box_valid<=0.
//   S_OUT: box_cx/box_cy recomputed from box regs; box_update=1 for exactly this cycle.
//  Latency: EOF detected at cycle N -> box_update high at N+4. Inputs are sampled at N+1.
//  An EOF arriving while not in S_IDLE is ignored; no queuing.
//  Async reset mid-sequence aborts immediately; all outputs return to reset values.
//  After reset, the first ok frame loads directly (no smoothing from 0).
//  box_* outputs change only in S_FILT; centre changes only in S_OUT; all outputs are stable between strobes.
// TESTING
//  T1 reset, frame box (100,200,50,150) -> update at N+4; box=(100,200,50,150), cx=150, cy=100, valid=1.
//  T2 then box (120,220,70,170), ALPHA_SHIFT=2 -> box=(105,205,55,155), cx=155, cy=105.
//  T3 old x_min=100, raw 102 -> 101; raw 98 -> 99 (|d|<4 still converges by 1).
//  T4 raw x_min=300 > x_max=200, or width 10 < MIN_W -> box held, miss_cnt 1,2,3; valid drops on 4th bad frame.
//  T5 after loss, good frame (10,40,10,40) -> direct load, valid=1, miss_cnt=0; 20 bad frames -> miss_cnt=15.
//  T6 rst_n low at S_FILT cycle -> all outputs 0, no update strobe; the next EOF is processed normally.

Source files
------------

// File: rtl/face_box_tracker_if.sv
// ============================================================
// face_box_tracker_if : raw box inputs and filtered box outputs
// Revision 1.0
// ============================================================
`default_nettype none

interface face_box_tracker_if;
  logic        per_frame_vsync;
  logic [11:0] x_min;
  logic [11:0] x_max;
  logic [11:0] y_min;
  logic [11:0] y_max;
  logic [11:0] box_x_min;
  logic [11:0] box_x_max;
  logic [11:0] box_y_min;
  logic [11:0] box_y_max;
  logic [11:0] box_cx;
  logic [11:0] box_cy;
  logic        box_valid;
  logic        box_update;
  logic [3:0]  miss_cnt;

  modport master (
    output per_frame_vsync, x_min, x_max, y_min, y_max,
    input  box_x_min, box_x_max, box_y_min, box_y_max,
           box_cx, box_cy, box_valid, box_update, miss_cnt
  );

  modport slave (
    input  per_frame_vsync, x_min, x_max, y_min, y_max,
    output box_x_min, box_x_max, box_y_min, box_y_max,
           box_cx, box_cy, box_valid, box_update, miss_cnt
  );
endinterface

`default_nettype wire

// File: rtl/face_box_tracker.sv
// ============================================================
// face_box_tracker : per-frame face box gating, IIR smoothing and miss tracking
// Revision 1.0
// ============================================================
`default_nettype none

module face_box_tracker #(
  parameter int IMG_HDISP   = 640,
  parameter int IMG_VDISP   = 480,
  parameter int MIN_W       = 16,
  parameter int MIN_H       = 16,
  parameter int ALPHA_SHIFT = 2,
  parameter int MISS_LIMIT  = 4
) (
  input wire                clk,
  input wire                rst_n,
  face_box_tracker_if.slave fb
);

  localparam logic [11:0] c_hdisp      = 12'(IMG_HDISP);
  localparam logic [11:0] c_vdisp      = 12'(IMG_VDISP);
  localparam logic [11:0] c_min_w      = 12'(MIN_W);
  localparam logic [11:0] c_min_h      = 12'(MIN_H);
  localparam logic [3:0]  c_miss_limit = 4'(MISS_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_CHECK = 3'd2,
    S_FILT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Coordinate index: 0 = x_min, 1 = x_max, 2 = y_min, 3 = y_max
  logic [3:0][11:0] raw_q, raw_d;
  logic [3:0][11:0] box_q, box_d;
  logic [11:0]      cx_q, cx_d;
  logic [11:0]      cy_q, cy_d;
  logic [3:0]       miss_q, miss_d;
  logic [3:0]       miss_inc;
  logic             vsync_q;
  logic             ok_q, ok_d;
  logic             valid_q, valid_d;
  logic             update_q, update_d;
  logic             eof;
  logic             raw_ok;

  assign eof = vsync_q & ~fb.per_frame_vsync;

  assign raw_ok = (raw_q[1] > raw_q[0]) && (raw_q[3] > raw_q[2]) &&
                  (raw_q[1] < c_hdisp)  && (raw_q[3] < c_vdisp)  &&
                  ((raw_q[1] - raw_q[0]) >= c_min_w) &&
                  ((raw_q[3] - raw_q[2]) >= c_min_h);

  // One IIR step; a nonzero error always moves by at least one pixel so the box converges
  function automatic logic [11:0] iir_step(input logic [11:0] old_v, input logic [11:0] raw_v);
    logic signed [12:0] d;
    logic signed [12:0] s;
    logic        [12:0] sum;
    d = $signed({1'b0, raw_v}) - $signed({1'b0, old_v});
    s = d >>> ALPHA_SHIFT;
    if ((s == '0) && (d != '0)) begin
      s = d[12] ? -13'sd1 : 13'sd1;
    end
    sum = {1'b0, old_v} + s;
    return sum[11:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    raw_d    = raw_q;
    ok_d     = ok_q;
    box_d    = box_q;
    valid_d  = valid_q;
    miss_d   = miss_q;
    update_d = 1'b0;
    miss_inc = (miss_q == 4'd15) ? 4'd15 : miss_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (eof) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        raw_d   = {fb.y_max, fb.y_min, fb.x_max, fb.x_min};
        state_d = S_CHECK;
      end
      S_CHECK: begin
        ok_d    = raw_ok;
        state_d = S_FILT;
      end
      S_FILT: begin
        if (ok_q) begin
          if (!valid_q) begin
            box_d   = raw_q;
            valid_d = 1'b1;
          end else begin
            for (int i = 0; i < 4; i++) begin
              box_d[i] = iir_step(box_q[i], raw_q[i]);
            end
          end
          miss_d = 4'd0;
        end else begin
          miss_d = miss_inc;
          if (miss_inc >= c_miss_limit) begin
            valid_d = 1'b0;
          end
        end
        update_d = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Centre registers on the FILT->OUT edge so it is valid for the whole strobe cycle
    cx_d = (state_q == S_FILT) ? 12'(({1'b0, box_d[0]} + {1'b0, box_d[1]}) >> 1) : cx_q;
    cy_d = (state_q == S_FILT) ? 12'(({1'b0, box_d[2]} + {1'b0, box_d[3]}) >> 1) : cy_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      raw_q    <= '0;
      ok_q     <= 1'b0;
      box_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      valid_q  <= 1'b0;
      miss_q   <= 4'd0;
      update_q <= 1'b0;
    end else begin
      vsync_q  <= fb.per_frame_vsync;
      raw_q    <= raw_d;
      ok_q     <= ok_d;
      box_q    <= box_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      valid_q  <= valid_d;
      miss_q   <= miss_d;
      update_q <= update_d;
    end
  end

  assign fb.box_x_min  = box_q[0];
  assign fb.box_x_max  = box_q[1];
  assign fb.box_y_min  = box_q[2];
  assign fb.box_y_max  = box_q[3];
  assign fb.box_cx     = cx_q;
  assign fb.box_cy     = cy_q;
  assign fb.box_valid  = valid_q;
  assign fb.box_update = update_q;
  assign fb.miss_cnt   = miss_q;

endmodule

`default_nettype wire
